// File: rtl/param_data_memory.sv
// rtl/param_data_memory.sv - parametrised byte-maskable data memory with registered read and clear sequencer
// Optional build macro: PARAM_DATA_MEMORY_BYPASS_EN (same-cycle write-to-read forwarding)
module param_data_memory #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DEPTH       = 256,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear_request,
  input  logic                    enable_write,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_mask,
  input  logic                    enable_read,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_valid,
  output logic                    busy,
  output logic                    addr_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   clear_count, clear_count_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    write_in_range, read_in_range;
  logic                    write_active, read_active;
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [BYTES-1:0]        mem_wmask;
  logic [DATA_WIDTH-1:0]   read_word;
  logic                    error_next;

  assign write_in_range = {1'b0, write_addr} < DEPTH_W;
  assign read_in_range  = {1'b0, read_addr} < DEPTH_W;

  // The clear sequencer owns the array write port while busy; user strobes only raise addr_error.
  always_comb begin
    state_next       = state;
    clear_count_next = clear_count;
    busy             = 1'b0;
    mem_we           = 1'b0;
    mem_waddr        = write_addr[IDX_W-1:0];
    mem_wdata        = write_data;
    mem_wmask        = write_mask;
    write_active     = 1'b0;
    read_active      = 1'b0;
    error_next       = 1'b0;
    case (state)
      CLEAR: begin
        busy       = 1'b1;
        mem_we     = 1'b1;
        mem_waddr  = clear_count[IDX_W-1:0];
        mem_wdata  = CLEAR_VALUE;
        mem_wmask  = '1;
        error_next = enable_write | enable_read;
        if (clear_count == LAST_ADDR) begin
          state_next       = IDLE;
          clear_count_next = '0;
        end else begin
          clear_count_next = clear_count + 1'b1;
        end
      end
      IDLE: begin
        write_active = enable_write & write_in_range & ~clear_request;
        read_active  = enable_read;
        mem_we       = write_active;
        error_next   = (enable_write & ~write_in_range) | (enable_read & ~read_in_range);
        if (clear_request) begin
          state_next = CLEAR;
        end
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  always_comb begin
    read_word = mem[read_addr[IDX_W-1:0]];
`ifdef PARAM_DATA_MEMORY_BYPASS_EN
    if (write_active && (write_addr == read_addr)) begin
      for (int i = 0; i < BYTES; i++) begin
        if (write_mask[i]) begin
          read_word[8*i +: 8] = write_data[8*i +: 8];
        end
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (mem_wmask[i]) begin
          mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= CLEAR;
      clear_count <= '0;
      read_data   <= '0;
      read_valid  <= 1'b0;
      addr_error  <= 1'b0;
    end else begin
      state       <= state_next;
      clear_count <= clear_count_next;
      addr_error  <= error_next;
      read_valid  <= read_active;
      if (read_active) begin
        read_data <= read_in_range ? read_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_param_data_memory.sv
// tb/tb_param_data_memory.sv - self-checking bench for param_data_memory (32-bit words, 200 deep)
// Expected read results honour PARAM_DATA_MEMORY_BYPASS_EN when it is defined.
`timescale 1ns/1ps
module tb_param_data_memory;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int BYTES = DW / 8;
  localparam logic [DW-1:0] CV = 32'h000000A5;
`ifdef PARAM_DATA_MEMORY_BYPASS_EN
  localparam logic [DW-1:0] SAME_CYCLE_READ = 32'h0000005A;
`else
  localparam logic [DW-1:0] SAME_CYCLE_READ = 32'h00000000;
`endif

  logic             clock = 1'b0;
  logic             reset_n;
  logic             clear_request;
  logic             enable_write;
  logic [AW-1:0]    write_addr;
  logic [DW-1:0]    write_data;
  logic [BYTES-1:0] write_mask;
  logic             enable_read;
  logic [AW-1:0]    read_addr;
  logic [DW-1:0]    read_data;
  logic             read_valid;
  logic             busy;
  logic             addr_error;

  always #5 clock = ~clock;

  param_data_memory #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .CLEAR_VALUE(CV)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear_request(clear_request),
    .enable_write (enable_write),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_mask   (write_mask),
    .enable_read  (enable_read),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .busy         (busy),
    .addr_error   (addr_error)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: word contents plus the number of cycles the clear still has to run.
  logic [DW-1:0] model_mem [0:255];
  int            clear_left;
  logic [DW-1:0] exp_data;
  logic          exp_valid;
  logic          exp_err;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [BYTES-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < BYTES; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    clear_left = DEPTH;
    for (int i = 0; i < 256; i++) model_mem[i] = CV;
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  task automatic cycle(input logic clr, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [BYTES-1:0] wm,
                       input logic re, input logic [AW-1:0] ra);
    logic busy_m, w_ok;
    busy_m = (clear_left > 0);
    w_ok   = !busy_m && we && !clr && (int'(wa) < DEPTH);
    clear_request = clr; enable_write = we; write_addr = wa; write_data = wd;
    write_mask = wm; enable_read = re; read_addr = ra;
    exp_valid = !busy_m && re;
    exp_err   = busy_m ? (we || re) : ((we && int'(wa) >= DEPTH) || (re && int'(ra) >= DEPTH));
    if (!busy_m && re) begin
      if (int'(ra) >= DEPTH) exp_data = '0;
      else begin
        exp_data = model_mem[ra];
`ifdef PARAM_DATA_MEMORY_BYPASS_EN
        if (w_ok && wa == ra) exp_data = merge(model_mem[ra], wd, wm);
`endif
      end
    end
    if (w_ok) model_mem[wa] = merge(model_mem[wa], wd, wm);
    if (busy_m) clear_left--;
    else if (clr) begin
      clear_left = DEPTH;
      for (int i = 0; i < 256; i++) model_mem[i] = CV;
    end
    @(posedge clock); #1;
    check("read_valid", {31'b0, read_valid}, {31'b0, exp_valid});
    check("read_data", read_data, exp_data);
    check("addr_error", {31'b0, addr_error}, {31'b0, exp_err});
    check("busy", {31'b0, busy}, {31'b0, clear_left > 0});
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cycle(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, a);
  endtask

  // Runs cycles while busy; with poke set it also tries an access and a second clear mid-way.
  task automatic wait_clear(input logic poke, output int n);
    n = 0;
    while (busy && n < 2 * DEPTH) begin
      if (poke && n == 0)       cycle(1'b0, 1'b1, 8'h03, 32'hCAFEF00D, 4'hF, 1'b1, 8'h03);
      else if (poke && n == 99) cycle(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
      else                      idle();
      n++;
    end
  endtask

  typedef struct {
    logic             clr, we;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [BYTES-1:0] wm;
    logic             re;
    logic [AW-1:0]    ra;
    logic             ev;
    logic [DW-1:0]    ed;
    logic             ee;
    logic             chk_data;
  } vec_t;

  vec_t tbl [14];
  int   n;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 8'h10, 32'h11223344, 4'hF, 1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h10, 32'hAABBCCDD, 4'h5, 1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h10, 1'b1, 32'h11BB33DD, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 8'h11, 32'hFFFFFFFF, 4'h0, 1'b1, 8'h11, 1'b1, CV,           1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 8'hF0, 32'h12345678, 4'hF, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'hF0, 1'b1, 32'h0,        1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 32'h0,        4'h0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'hC7, 1'b1, CV,           1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'hC8, 1'b1, 32'h0,        1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 8'h20, 32'h0,        4'hF, 1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h20, 32'h5A,       4'hF, 1'b1, 8'h20, 1'b1, SAME_CYCLE_READ, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h20, 1'b1, 32'h5A,       1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h00, 1'b1, CV,           1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h80, 1'b1, CV,           1'b0, 1'b1};

    reset_n = 1'b1; clear_request = 1'b0; enable_write = 1'b0; write_addr = '0;
    write_data = '0; write_mask = '0; enable_read = 1'b0; read_addr = '0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_valid", {31'b0, read_valid}, 32'd0);
    check("rst_data", read_data, 32'h0);
    check("rst_err", {31'b0, addr_error}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_reset();
    wait_clear(1'b0, n);
    check("init_clear_len", n, DEPTH);
    rd(8'h00);  check("init_rd0", read_data, CV);
    rd(8'h80);  check("init_rd128", read_data, CV);
    rd(8'hC7);  check("init_rd199", read_data, CV);

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].clr, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wm, tbl[i].re, tbl[i].ra);
      check($sformatf("tbl%0d_valid", i), {31'b0, read_valid}, {31'b0, tbl[i].ev});
      check($sformatf("tbl%0d_err", i), {31'b0, addr_error}, {31'b0, tbl[i].ee});
      if (tbl[i].chk_data) check($sformatf("tbl%0d_data", i), read_data, tbl[i].ed);
    end

    // Clear request with a colliding write; the read in that cycle still completes.
    cycle(1'b1, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 1'b1, 8'h10);
    check("clr_rd_data", read_data, 32'h11BB33DD);
    check("clr_busy", {31'b0, busy}, 32'd1);
    wait_clear(1'b1, n);
    check("req_clear_len", n, DEPTH);
    rd(8'h05);  check("clr_dropped_wr", read_data, CV);
    rd(8'h10);  check("clr_wiped", read_data, CV);

    // Reset 50 cycles into a clear, with addr_error high just before it.
    cycle(1'b0, 1'b1, 8'h30, 32'h12345678, 4'hF, 1'b0, 8'h00);
    rd(8'h30);
    cycle(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
    for (int i = 0; i < 48; i++) idle();
    cycle(1'b0, 1'b1, 8'h30, 32'h1, 4'hF, 1'b1, 8'h30);
    check("pre_rst_err", {31'b0, addr_error}, 32'd1);
    reset_n = 1'b0;
    #2;
    check("mid_rst_busy", {31'b0, busy}, 32'd1);
    check("mid_rst_valid", {31'b0, read_valid}, 32'd0);
    check("mid_rst_data", read_data, 32'h0);
    check("mid_rst_err", {31'b0, addr_error}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_reset();
    wait_clear(1'b0, n);
    check("rst_clear_len", n, DEPTH);
    rd(8'h30);  check("rst_rd30", read_data, CV);

    for (int i = 0; i < 600; i++) begin
      logic clr, we, re;
      logic [AW-1:0] wa, ra;
      clr = ($urandom_range(0, 199) == 0);
      we  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      wa  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      cycle(clr, we, wa, $urandom, 4'($urandom_range(0, 15)), re, ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
